// File: rtl/elm_pkg.sv
// Shared types and constants for the ELM inference prediction path:
// record format, error-flag bit positions and label FSM states.
package elm_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int INDEX_W     = 4;

  localparam int OVF      = 2;
  localparam int BAD_IDX  = 1;
  localparam int MISS_LBL = 0;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic               correct;
  } pred_rec_t;

  typedef enum logic {
    LBL_EMPTY,
    LBL_HELD
  } lbl_state_t;

endpackage

// File: rtl/pred_fifo.sv
// DEPTH-entry FIFO of prediction records; DEPTH must be a power of two.
// A push while full is accepted only if a pop frees a slot that cycle.
module pred_fifo
  import elm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  pred_rec_t i_rec,
  input  logic      i_pop,
  output pred_rec_t o_head,
  output logic      o_full,
  output logic      o_empty,
  output logic      o_drop
);

  localparam int AW = $clog2(DEPTH);

  pred_rec_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_drop  = i_push & ~w_push;
  assign o_head  = r_mem[r_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_rec;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/prediction_collector.sv
// Pairs argmax predictions with expected labels, keeps saturating stats
// and queues {index, correct} records. Option: PRED_CLASS_STATS_EN.
module prediction_collector #(
  parameter int NUM_CLASSES = elm_pkg::NUM_CLASSES,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       index,
  input  logic             update,
  input  logic             label_valid,
  input  logic [3:0]       label,
  output logic             label_ready,
  output logic             pred_valid,
  output logic [3:0]       pred_index,
  output logic             pred_correct,
  input  logic             pred_ready,
  output logic [CNT_W-1:0] total_count,
  output logic [CNT_W-1:0] correct_count,
  output logic [2:0]       err_flags
`ifdef PRED_CLASS_STATS_EN
  ,
  input  logic [3:0]       class_sel,
  output logic [CNT_W-1:0] class_correct
`endif
);

  import elm_pkg::*;

  localparam logic [3:0]       LP_NC  = 4'(NUM_CLASSES);
  localparam logic [CNT_W-1:0] LP_MAX = '1;

  lbl_state_t       r_state;
  lbl_state_t       w_state_nxt;
  logic             w_lbl_rdy;
  logic [3:0]       r_label;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_correct;
  logic [2:0]       r_err;
  logic             w_miss;
  logic             w_bad;
  logic             w_correct;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  pred_rec_t        w_rec;
  pred_rec_t        w_head;

  always_comb begin
    w_state_nxt = r_state;
    w_lbl_rdy   = 1'b0;
    unique case (r_state)
      LBL_EMPTY: begin
        w_lbl_rdy = 1'b1;
        if (label_valid) w_state_nxt = LBL_HELD;
      end
      LBL_HELD: if (update) w_state_nxt = LBL_EMPTY;
      default: w_state_nxt = LBL_EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= LBL_EMPTY;
      r_label <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (label_valid && w_lbl_rdy) r_label <= label;
    end
  end

  // A label arriving with an update in EMPTY belongs to the next prediction.
  assign w_miss    = update && (r_state == LBL_EMPTY);
  assign w_bad     = update && (index >= LP_NC);
  assign w_correct = update && (r_state == LBL_HELD) &&
                     !w_bad && (index == r_label);

  assign w_rec.index   = index;
  assign w_rec.correct = w_correct;

  pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_push  (update),
    .i_rec   (w_rec),
    .i_pop   (pred_ready),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_total   <= '0;
      r_correct <= '0;
      r_err     <= '0;
    end else begin
      if (update && r_total != LP_MAX) r_total <= r_total + 1'b1;
      if (w_correct && r_correct != LP_MAX)
        r_correct <= r_correct + 1'b1;
      if (w_miss) r_err[MISS_LBL] <= 1'b1;
      if (w_bad)  r_err[BAD_IDX]  <= 1'b1;
      if (w_drop) r_err[OVF]      <= 1'b1;
    end
  end

`ifdef PRED_CLASS_STATS_EN
  logic [CNT_W-1:0] r_cls [NUM_CLASSES];
  logic [CNT_W-1:0] r_cls_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLASSES; i++) r_cls[i] <= '0;
      r_cls_q <= '0;
    end else begin
      if (w_correct && r_cls[r_label] != LP_MAX)
        r_cls[r_label] <= r_cls[r_label] + 1'b1;
      if (class_sel < LP_NC) r_cls_q <= r_cls[class_sel];
      else                   r_cls_q <= '0;
    end
  end

  assign class_correct = r_cls_q;
`endif

  assign label_ready   = w_lbl_rdy;
  assign pred_valid    = ~w_empty;
  assign pred_index    = w_head.index;
  assign pred_correct  = w_head.correct;
  assign total_count   = r_total;
  assign correct_count = r_correct;
  assign err_flags     = r_err;

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_prediction_collector.sv
// Directed bench for prediction_collector; a second instance with
// 4-bit counters shares the stimulus to exercise saturation.
module tb_prediction_collector;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  index;
  logic        update;
  logic        label_valid;
  logic [3:0]  label;
  logic        pred_ready;

  logic        label_ready, pred_valid, pred_correct;
  logic [3:0]  pred_index;
  logic [15:0] total_count, correct_count;
  logic [2:0]  err_flags;

  logic        s_label_ready, s_pred_valid, s_pred_correct;
  logic [3:0]  s_pred_index;
  logic [3:0]  s_total, s_correct;
  logic [2:0]  s_err;

`ifdef PRED_CLASS_STATS_EN
  logic [3:0]  class_sel = '0;
  logic [15:0] class_correct;
  logic [3:0]  s_class_correct;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  prediction_collector dut (
    .clock         (clock),
    .reset         (reset),
    .index         (index),
    .update        (update),
    .label_valid   (label_valid),
    .label         (label),
    .label_ready   (label_ready),
    .pred_valid    (pred_valid),
    .pred_index    (pred_index),
    .pred_correct  (pred_correct),
    .pred_ready    (pred_ready),
    .total_count   (total_count),
    .correct_count (correct_count),
    .err_flags     (err_flags)
`ifdef PRED_CLASS_STATS_EN
    ,
    .class_sel     (class_sel),
    .class_correct (class_correct)
`endif
  );

  prediction_collector #(.CNT_W(4)) dut_sat (
    .clock         (clock),
    .reset         (reset),
    .index         (index),
    .update        (update),
    .label_valid   (label_valid),
    .label         (label),
    .label_ready   (s_label_ready),
    .pred_valid    (s_pred_valid),
    .pred_index    (s_pred_index),
    .pred_correct  (s_pred_correct),
    .pred_ready    (pred_ready),
    .total_count   (s_total),
    .correct_count (s_correct),
    .err_flags     (s_err)
`ifdef PRED_CLASS_STATS_EN
    ,
    .class_sel     (class_sel),
    .class_correct (s_class_correct)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic give_label(input logic [3:0] l);
    label_valid = 1'b1;
    label       = l;
    tick();
    label_valid = 1'b0;
  endtask

  task automatic predict(input logic [3:0] idx);
    update = 1'b1;
    index  = idx;
    tick();
    update = 1'b0;
  endtask

  initial begin
    reset = 1'b1; index = '0; update = 1'b0;
    label_valid = 1'b0; label = '0; pred_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    check("rst_label_ready", 32'(label_ready), 32'd1);
    check("rst_pred_valid", 32'(pred_valid), 32'd0);
    check("rst_pred_index", 32'(pred_index), 32'd0);
    check("rst_pred_correct", 32'(pred_correct), 32'd0);
    check("rst_total", 32'(total_count), 32'd0);
    check("rst_correct", 32'(correct_count), 32'd0);
    check("rst_err", 32'(err_flags), 32'd0);

    give_label(4'd7);
    check("t1_label_held", 32'(label_ready), 32'd0);
    predict(4'd7);
    check("t1_label_ready", 32'(label_ready), 32'd1);
    check("t1_valid", 32'(pred_valid), 32'd1);
    check("t1_index", 32'(pred_index), 32'd7);
    check("t1_correct", 32'(pred_correct), 32'd1);
    check("t1_total", 32'(total_count), 32'd1);
    check("t1_ccount", 32'(correct_count), 32'd1);
    pred_ready = 1'b1;
    tick();
    pred_ready = 1'b0;
    check("t1_popped", 32'(pred_valid), 32'd0);

    do_reset();
    give_label(4'd3);
    pred_ready = 1'b1;
    predict(4'd5);
    pred_ready = 1'b0;
    check("t2_valid_empty_pop", 32'(pred_valid), 32'd1);
    check("t2_index", 32'(pred_index), 32'd5);
    check("t2_correct", 32'(pred_correct), 32'd0);
    check("t2_total", 32'(total_count), 32'd1);
    check("t2_ccount", 32'(correct_count), 32'd0);
    check("t2_err", 32'(err_flags), 32'd0);

    do_reset();
    label_valid = 1'b1;
    label = 4'd4;
    predict(4'd2);
    label_valid = 1'b0;
    check("t3_index", 32'(pred_index), 32'd2);
    check("t3_correct", 32'(pred_correct), 32'd0);
    check("t3_err", 32'(err_flags), 32'b001);
    check("t3_held", 32'(label_ready), 32'd0);
    predict(4'd4);
    check("t3_total", 32'(total_count), 32'd2);
    check("t3_ccount", 32'(correct_count), 32'd1);
    check("t3_head_stable", 32'(pred_index), 32'd2);
    pred_ready = 1'b1;
    tick();
    pred_ready = 1'b0;
    check("t3_next_index", 32'(pred_index), 32'd4);
    check("t3_next_correct", 32'(pred_correct), 32'd1);

    do_reset();
    for (int k = 0; k < 9; k++) begin
      give_label(4'(k));
      predict(4'(k));
    end
    check("t4_total", 32'(total_count), 32'd9);
    check("t4_ccount", 32'(correct_count), 32'd9);
    check("t4_err", 32'(err_flags), 32'b100);
    pred_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t4_valid%0d", k), 32'(pred_valid), 32'd1);
      check($sformatf("t4_index%0d", k), 32'(pred_index), 32'(k));
      check($sformatf("t4_corr%0d", k), 32'(pred_correct), 32'd1);
      tick();
    end
    pred_ready = 1'b0;
    check("t4_drained", 32'(pred_valid), 32'd0);

    do_reset();
    give_label(4'd12);
    predict(4'd12);
    check("t5_correct", 32'(pred_correct), 32'd0);
    check("t5_err", 32'(err_flags), 32'b010);
    check("t5_ccount", 32'(correct_count), 32'd0);

    do_reset();
    update = 1'b1;
    index  = 4'd1;
    for (int k = 0; k < 17; k++) tick();
    update = 1'b0;
    check("t6_sat_total", 32'(s_total), 32'd15);
    check("t6_sat_ccount", 32'(s_correct), 32'd0);
    check("t6_wide_total", 32'(total_count), 32'd17);
    check("t6_err", 32'(err_flags), 32'b101);

    do_reset();
    for (int k = 0; k < 3; k++) predict(4'(k));
    give_label(4'd6);
    check("t7_valid_before", 32'(pred_valid), 32'd1);
    check("t7_held_before", 32'(label_ready), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("t7_async_valid", 32'(pred_valid), 32'd0);
    check("t7_async_total", 32'(total_count), 32'd0);
    check("t7_async_label_ready", 32'(label_ready), 32'd1);
    check("t7_async_err", 32'(err_flags), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
